// File: rtl/freq_meter_pkg.sv
// freq_meter shared types and helpers.
// Imported by the frequency meter top level.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 32;

    function automatic int gate_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter control/result bundle.
// The master drives stimulus; the slave is the meter.
interface freq_meter_if #(
    parameter int CntWidth = 32
);
    logic                sig_in;
    logic                start;
    logic                mode_cont;
    logic [CntWidth-1:0] count;
    logic                valid;
    logic                busy;
    logic                overflow;

    modport master (
        output sig_in, start, mode_cont,
        input  count, valid, busy, overflow
    );

    modport slave (
        input  sig_in, start, mode_cont,
        output count, valid, busy, overflow
    );
endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchronizer plus history flop.
// o_rise pulses for one clk per synchronized rising edge.
module sync_edge_det #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);
    logic [SyncStages-1:0] r_sync;
    logic                  r_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], i_sig};
            r_hist <= r_sync[SyncStages-1];
        end
    end

    assign o_rise = r_sync[SyncStages-1] & ~r_hist;
endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rises over GateCycles clk cycles.
// Continuous mode re-arms the window with no dead time.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int OscF       = 24_000_000,
    parameter int GateCycles = OscF,
    parameter int CntWidth   = CNT_W_DEF,
    parameter int SyncStages = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    freq_meter_if.slave  bus
);
    localparam int GW = gate_w(GateCycles);
    localparam int AW = gate_w(SyncStages + 2);
    localparam logic [CntWidth-1:0] CNT_MAX = CntWidth'(sat_max(CntWidth));
    localparam logic [GW-1:0] GATE_LAST = GW'(GateCycles - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(SyncStages);

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_arm_ctr;
    logic [GW-1:0]       r_gate_ctr;
    logic [CntWidth-1:0] r_edge_ctr;
    logic [CntWidth-1:0] r_count;
    logic                r_ovf;
    logic                r_valid;
    logic                r_overflow;

    logic                w_rise;
    logic                w_arm_done;
    logic                w_gate_last;
    logic                w_sum_ovf;
    logic [CntWidth-1:0] w_edge_sum;

    sync_edge_det #(
        .SyncStages(SyncStages)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sig (bus.sig_in),
        .o_rise(w_rise)
    );

    always_comb begin
        w_arm_done  = (r_state == ST_ARM) && (r_arm_ctr == ARM_LAST);
        w_gate_last = (r_state == ST_GATE) && (r_gate_ctr == GATE_LAST);
        w_sum_ovf   = w_rise && (r_edge_ctr == CNT_MAX);
        w_edge_sum  = w_sum_ovf ? CNT_MAX : r_edge_ctr + CntWidth'(w_rise);
        w_next      = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_ARM;
            ST_ARM:  if (w_arm_done) w_next = ST_GATE;
            ST_GATE: if (w_gate_last && !bus.mode_cont) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_arm_ctr  <= '0;
            r_gate_ctr <= '0;
            r_edge_ctr <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            if (r_state == ST_ARM) begin
                r_arm_ctr  <= w_arm_done ? '0 : r_arm_ctr + AW'(1);
                r_gate_ctr <= '0;
                r_edge_ctr <= '0;
                r_ovf      <= 1'b0;
            end else if (r_state == ST_GATE) begin
                // Final cycle folds in its own rise before publishing.
                if (w_gate_last) begin
                    r_count    <= w_edge_sum;
                    r_overflow <= r_ovf | w_sum_ovf;
                    r_valid    <= 1'b1;
                    r_gate_ctr <= '0;
                    r_edge_ctr <= '0;
                    r_ovf      <= 1'b0;
                end else begin
                    r_gate_ctr <= r_gate_ctr + GW'(1);
                    r_edge_ctr <= w_edge_sum;
                    r_ovf      <= r_ovf | w_sum_ovf;
                end
            end else begin
                r_arm_ctr <= '0;
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.valid    = r_valid;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: 32-bit and 3-bit counter instances.
// Expected results are queued at start and checked on each valid pulse.
module tb_freq_meter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig = 1'b0;
    int   per = 0;
    int   ph = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    freq_meter_if #(.CntWidth(32)) ifa ();
    freq_meter_if #(.CntWidth(3))  ifb ();

    freq_meter #(
        .OscF(24_000_000), .GateCycles(100), .CntWidth(32), .SyncStages(2)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa.slave)
    );

    freq_meter #(
        .OscF(24_000_000), .GateCycles(100), .CntWidth(3), .SyncStages(2)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb.slave)
    );

    assign ifa.sig_in = sig;
    assign ifb.sig_in = sig;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Periodic generator; per==0 leaves sig to the test sequence.
    initial begin
        forever begin
            @(negedge clk);
            if (per != 0) begin
                ph  = (ph + 1) % per;
                sig = (ph < per / 2);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (ifa.valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_count", 64'(ifa.count), 64'(e.cnt));
                chk("a_overflow", 64'(ifa.overflow), 64'(e.ovf));
                chk("a_valid_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (ifb.valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_count", 64'(ifb.count), 64'(e.cnt));
                chk("b_overflow", 64'(ifb.overflow), 64'(e.ovf));
                chk("b_valid_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic start_a(output int c0);
        @(negedge clk);
        ifa.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    task automatic start_b(output int c0);
        @(negedge clk);
        ifb.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        ifb.start = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] c, input logic o, input int at);
        exp_t e;
        e.cnt = c;
        e.ovf = o;
        e.at  = at;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] c, input logic o, input int at);
        exp_t e;
        e.cnt = c;
        e.ovf = o;
        e.at  = at;
        qb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic set_idle_level(input logic lvl);
        per = 0;
        @(negedge clk);
        sig = lvl;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int c0;
        int b;
        ifa.start = 1'b0;
        ifa.mode_cont = 1'b0;
        ifb.start = 1'b0;
        ifb.mode_cont = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_count", 64'(ifa.count), 64'd0);
        chk("rst_valid", 64'(ifa.valid), 64'd0);
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_overflow", 64'(ifa.overflow), 64'd0);
        rst_n = 1'b1;

        // Period 10 single shot: latency and busy length.
        per = 10;
        repeat (10) @(negedge clk);
        start_a(c0);
        push_a(32'd10, 1'b0, c0 + 104);
        b = 0;
        while (ifa.busy && b < 300) begin
            b++;
            @(negedge clk);
        end
        chk("busy_len", 64'(b), 64'd103);
        drain(50);

        set_idle_level(1'b1);
        start_a(c0);
        push_a(32'd0, 1'b0, c0 + 104);
        drain(200);

        per = 2;
        repeat (10) @(negedge clk);
        start_a(c0);
        push_a(32'd50, 1'b0, c0 + 104);
        drain(200);

        // Rise on the final gate cycle is counted.
        set_idle_level(1'b0);
        start_a(c0);
        push_a(32'd1, 1'b0, c0 + 104);
        repeat (100) @(negedge clk);
        sig = 1'b1;
        drain(200);

        // Rise seen only during ARM is discarded.
        set_idle_level(1'b0);
        start_a(c0);
        sig = 1'b1;
        push_a(32'd0, 1'b0, c0 + 104);
        drain(200);

        // Continuous: three windows, stray start, drop mode in window 3.
        per = 10;
        repeat (10) @(negedge clk);
        ifa.mode_cont = 1'b1;
        start_a(c0);
        push_a(32'd10, 1'b0, c0 + 104);
        push_a(32'd10, 1'b0, c0 + 204);
        push_a(32'd10, 1'b0, c0 + 304);
        repeat (150) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        b = 0;
        while (qa.size() > 1 && b < 200) begin
            b++;
            @(negedge clk);
        end
        chk("cont_w2_seen", 64'(qa.size()), 64'd1);
        repeat (50) @(negedge clk);
        ifa.mode_cont = 1'b0;
        drain(200);
        repeat (2) @(negedge clk);
        chk("cont_idle_busy", 64'(ifa.busy), 64'd0);
        repeat (150) @(negedge clk);

        // Reset at gate cycle 50 aborts the window silently.
        start_a(c0);
        repeat (52) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_count", 64'(ifa.count), 64'd0);
        chk("mid_rst_valid", 64'(ifa.valid), 64'd0);
        chk("mid_rst_busy", 64'(ifa.busy), 64'd0);
        chk("mid_rst_overflow", 64'(ifa.overflow), 64'd0);
        repeat (150) @(negedge clk);
        chk("mid_rst_idle", 64'(ifa.busy), 64'd0);
        start_a(c0);
        push_a(32'd10, 1'b0, c0 + 104);
        drain(200);

        // Narrow counter saturates, then clears on a quiet window.
        per = 4;
        repeat (10) @(negedge clk);
        start_b(c0);
        push_b(32'd7, 1'b1, c0 + 104);
        drain(200);
        set_idle_level(1'b0);
        start_b(c0);
        push_b(32'd0, 1'b0, c0 + 104);
        drain(200);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
